// File: rtl/melody_pkg.sv
// Shared constants for the melody sequencer: note codes, tone periods,
// duration codes, FSM state encoding and the default song table.
package melody_pkg;

   localparam logic [3:0] NOTE_REST    = 4'd0;
   localparam logic [3:0] NOTE_DO      = 4'd1;
   localparam logic [3:0] NOTE_RAE     = 4'd2;
   localparam logic [3:0] NOTE_MI      = 4'd3;
   localparam logic [3:0] NOTE_FA      = 4'd4;
   localparam logic [3:0] NOTE_SOL     = 4'd5;
   localparam logic [3:0] NOTE_LA      = 4'd6;
   localparam logic [3:0] NOTE_TI      = 4'd7;
   localparam logic [3:0] NOTE_HIGH_DO = 4'd8;

   localparam logic [11:0] PER_DO      = 12'd3830;
   localparam logic [11:0] PER_RAE     = 12'd3400;
   localparam logic [11:0] PER_MI      = 12'd3038;
   localparam logic [11:0] PER_FA      = 12'd2864;
   localparam logic [11:0] PER_SOL     = 12'd2550;
   localparam logic [11:0] PER_LA      = 12'd2272;
   localparam logic [11:0] PER_TI      = 12'd2028;
   localparam logic [11:0] PER_HIGH_DO = 12'd1912;

   localparam logic [1:0] DUR_END = 2'd0;
   localparam logic [1:0] DUR_1   = 2'd1;
   localparam logic [1:0] DUR_2   = 2'd2;
   localparam logic [1:0] DUR_4   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int DEFAULT_LEN = 16;

   // Entry i lives at bits [6*i +: 6] as {note, dur}.
   localparam logic [DEFAULT_LEN*6-1:0] DEFAULT_SONG = {
      {7{6'h00}},
      {NOTE_REST,    DUR_END},
      {NOTE_HIGH_DO, DUR_4},
      {NOTE_TI,      DUR_1},
      {NOTE_LA,      DUR_1},
      {NOTE_SOL,     DUR_2},
      {NOTE_FA,      DUR_1},
      {NOTE_MI,      DUR_1},
      {NOTE_RAE,     DUR_1},
      {NOTE_DO,      DUR_1}
   };

   function automatic logic [2:0] dur_beats(input logic [1:0] d);
      case (d)
         DUR_1:   dur_beats = 3'd1;
         DUR_2:   dur_beats = 3'd2;
         DUR_4:   dur_beats = 3'd4;
         default: dur_beats = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control strobes and tone outputs of the melody sequencer.
// start/stop are single-cycle strobes; there is no valid/ready handshake.
interface melody_sequencer_if;
   logic        start;
   logic        stop;
   logic [11:0] tone_limit;
   logic        tone_en;
   logic        busy;
   logic        done;
   logic [3:0]  note_idx;

   modport master (
      output start, stop,
      input  tone_limit, tone_en, busy, done, note_idx
   );

   modport slave (
      input  start, stop,
      output tone_limit, tone_en, busy, done, note_idx
   );
endinterface

// File: rtl/note_rom.sv
// Note code to tone period lookup; rests and reserved codes give 0.
module note_rom
   import melody_pkg::*;
(
   input  logic [3:0]  i_note,
   output logic [11:0] o_period
);

   always_comb begin
      case (i_note)
         NOTE_DO:      o_period = PER_DO;
         NOTE_RAE:     o_period = PER_RAE;
         NOTE_MI:      o_period = PER_MI;
         NOTE_FA:      o_period = PER_FA;
         NOTE_SOL:     o_period = PER_SOL;
         NOTE_LA:      o_period = PER_LA;
         NOTE_TI:      o_period = PER_TI;
         NOTE_HIGH_DO: o_period = PER_HIGH_DO;
         default:      o_period = 12'd0;
      endcase
   end

endmodule

// File: rtl/melody_sequencer.sv
// Song-table note sequencer: plays each entry for beats*BEAT_CYCLES clocks,
// the last GAP_CYCLES of which are silent, with fully registered outputs.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int BEAT_CYCLES = 250000,
   parameter int GAP_CYCLES  = 20000,
   parameter int SONG_LEN    = 16,
   parameter int LOOP        = 0,
   parameter logic [SONG_LEN*6-1:0] SONG_TABLE = DEFAULT_SONG
)(
   input  logic                clk,
   input  logic                rst,
   melody_sequencer_if.slave   bus,
   output state_t              o_dbg_state
);

   localparam int TW = $clog2(4*BEAT_CYCLES);
   localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

   // Timer holds cycles remaining minus one, so a state lasts load+1 cycles.
   function automatic logic [TW-1:0] play_load(input logic [1:0] d);
      play_load = TW'(int'(dur_beats(d)) * BEAT_CYCLES - GAP_CYCLES - 1);
   endfunction

   logic [5:0] w_song [SONG_LEN];
   for (genvar g = 0; g < SONG_LEN; g++) begin : g_song
      assign w_song[g] = SONG_TABLE[6*g +: 6];
   end

   state_t      r_state, w_state_n;
   logic [TW-1:0] r_timer, w_timer_n;
   logic [3:0]  r_idx, w_idx_n, w_idx_inc;
   logic        r_done, w_done_n;
   logic [11:0] r_tone_limit, w_tone_limit_n;
   logic        r_tone_en, w_tone_en_n;
   logic        r_busy, w_busy_n;
   logic        w_last;
   logic [11:0] w_period;

   assign w_idx_inc = r_idx + 4'd1;
   assign w_last    = (r_idx == 4'(SONG_LEN - 1)) || (w_song[w_idx_inc][1:0] == DUR_END);

   always_comb begin
      w_state_n = r_state;
      w_timer_n = r_timer - 1'b1;
      w_idx_n   = r_idx;
      w_done_n  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_timer_n = '0;
            w_idx_n   = '0;
            if (bus.start && !bus.stop) begin
               if (w_song[0][1:0] == DUR_END) begin
                  w_done_n = 1'b1;
               end else begin
                  w_state_n = ST_PLAY;
                  w_timer_n = play_load(w_song[0][1:0]);
               end
            end
         end
         ST_PLAY: begin
            if (bus.stop) begin
               w_state_n = ST_IDLE;
               w_timer_n = '0;
               w_idx_n   = '0;
            end else if (r_timer == '0) begin
               w_state_n = ST_GAP;
               w_timer_n = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (bus.stop) begin
               w_state_n = ST_IDLE;
               w_timer_n = '0;
               w_idx_n   = '0;
            end else if (r_timer == '0) begin
               if (w_last) begin
                  w_done_n = 1'b1;
                  w_idx_n  = '0;
                  if (LOOP != 0) begin
                     w_state_n = ST_PLAY;
                     w_timer_n = play_load(w_song[0][1:0]);
                  end else begin
                     w_state_n = ST_IDLE;
                     w_timer_n = '0;
                  end
               end else begin
                  w_state_n = ST_PLAY;
                  w_idx_n   = w_idx_inc;
                  w_timer_n = play_load(w_song[w_idx_inc][1:0]);
               end
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_timer_n = '0;
            w_idx_n   = '0;
         end
      endcase
   end

   // Outputs are computed from the next state so they register in step with it.
   note_rom u_note_rom (
      .i_note   (w_song[w_idx_n][5:2]),
      .o_period (w_period)
   );

   always_comb begin
      w_busy_n       = (w_state_n != ST_IDLE);
      w_tone_limit_n = (w_state_n == ST_PLAY) ? w_period : 12'd0;
      w_tone_en_n    = (w_state_n == ST_PLAY) && (w_period != 12'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_idx        <= '0;
         r_done       <= 1'b0;
         r_tone_limit <= 12'd0;
         r_tone_en    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_timer      <= w_timer_n;
         r_idx        <= w_idx_n;
         r_done       <= w_done_n;
         r_tone_limit <= w_tone_limit_n;
         r_tone_en    <= w_tone_en_n;
         r_busy       <= w_busy_n;
      end
   end

   assign bus.tone_limit = r_tone_limit;
   assign bus.tone_en    = r_tone_en;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.note_idx   = r_idx;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: three instances (one-shot, looping, empty song)
// checked cycle by cycle against a trace built from the song rules.
module tb_melody_sequencer;
   import melody_pkg::*;

   localparam int BEAT = 10;
   localparam int GAP  = 2;

   // Reference song, entry i at [6*i +: 6] = {note, dur}.
   localparam logic [95:0] TB_SONG = {42'h0, 6'b0000_00, 6'b1000_11, 6'b0111_01,
      6'b0110_01, 6'b0101_10, 6'b0100_01, 6'b0011_01, 6'b0010_01, 6'b0001_01};

   logic clk;
   logic rst;
   state_t dbg0, dbg1, dbg2;

   melody_sequencer_if if0 ();
   melody_sequencer_if if1 ();
   melody_sequencer_if if2 ();

   melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(16), .LOOP(0))
      dut0 (.clk(clk), .rst(rst), .bus(if0), .o_dbg_state(dbg0));
   melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(16), .LOOP(1))
      dut1 (.clk(clk), .rst(rst), .bus(if1), .o_dbg_state(dbg1));
   melody_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(16), .LOOP(0),
      .SONG_TABLE('0))
      dut2 (.clk(clk), .rst(rst), .bus(if2), .o_dbg_state(dbg2));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: row = {done, busy, tone_en, note_idx[3:0], tone_limit[11:0]}
   logic [18:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [11:0] tb_period(input logic [3:0] n);
      logic [11:0] tab [16];
      tab = '{12'd0, 12'd3830, 12'd3400, 12'd3038, 12'd2864, 12'd2550, 12'd2272,
              12'd2028, 12'd1912, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
      return tab[n];
   endfunction

   task automatic build_trace(input logic [95:0] tbl, input bit loop);
      logic [5:0]  e;
      logic [11:0] per;
      logic [18:0] first;
      int          beats;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         e = tbl[6*i +: 6];
         if (e[1:0] == 2'd0) break;
         beats = (e[1:0] == 2'd3) ? 4 : int'(e[1:0]);
         per = tb_period(e[5:2]);
         for (int c = 0; c < beats*BEAT - GAP; c++)
            exp_q.push_back({1'b0, 1'b1, per != 12'd0, 4'(i), per});
         for (int c = 0; c < GAP; c++)
            exp_q.push_back({1'b0, 1'b1, 1'b0, 4'(i), 12'd0});
      end
      if (loop) begin
         first = exp_q[0];
         first[18] = 1'b1;
         exp_q.push_back(first);
         for (int c = 1; c < 10; c++) exp_q.push_back(exp_q[c]);
      end else begin
         exp_q.push_back(19'h40000);
         exp_q.push_back(19'h00000);
      end
   endtask

   function automatic logic [18:0] obs(input int w);
      case (w)
         0:       obs = {if0.done, if0.busy, if0.tone_en, if0.note_idx, if0.tone_limit};
         1:       obs = {if1.done, if1.busy, if1.tone_en, if1.note_idx, if1.tone_limit};
         default: obs = {if2.done, if2.busy, if2.tone_en, if2.note_idx, if2.tone_limit};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // driver tasks
   task automatic set_start(input int w, input logic v);
      case (w)
         0:       if0.start = v;
         1:       if1.start = v;
         default: if2.start = v;
      endcase
   endtask

   task automatic set_stop(input int w, input logic v);
      case (w)
         0:       if0.stop = v;
         1:       if1.stop = v;
         default: if2.stop = v;
      endcase
   endtask

   task automatic pulse_start(input int w);
      set_start(w, 1'b1);
      @(negedge clk);
      set_start(w, 1'b0);
   endtask

   task automatic pulse_stop(input int w);
      set_stop(w, 1'b1);
      @(negedge clk);
      set_stop(w, 1'b0);
   endtask

   // Checks rows first..last, one per cycle; optional spurious starts while busy.
   task automatic check_rows(input string tag, input int w, input int first,
                             input int last, input bit rnd);
      logic [18:0] row;
      for (int r = first; r <= last; r++) begin
         row = exp_q[r];
         chk($sformatf("%s_row%0d", tag, r), obs(w), row);
         if (r != last) begin
            set_start(w, rnd && row[17] && ($urandom_range(0, 4) == 0));
            @(negedge clk);
         end
      end
      set_start(w, 1'b0);
   endtask

   task automatic check_idle(input string tag, input int w, input int n);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_%0d", tag, i), obs(w), 19'h00000);
         @(negedge clk);
      end
   endtask

   initial begin
      int stop_at;
      rst = 1'b1;
      if0.start = 1'b0; if0.stop = 1'b0;
      if1.start = 1'b0; if1.stop = 1'b0;
      if2.start = 1'b0; if2.stop = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_dut0", obs(0), 19'h00000);
      chk("reset_dut1", obs(1), 19'h00000);
      chk("reset_dut2", obs(2), 19'h00000);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a note
      build_trace(TB_SONG, 1'b0);
      pulse_start(0);
      check_rows("pre_reset", 0, 0, 4, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_reset", obs(0), 19'h00000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("after_reset", obs(0), 19'h00000);

      // Full song with ignored starts sprinkled through playback
      pulse_start(0);
      check_rows("full", 0, 0, exp_q.size() - 1, 1'b1);
      @(negedge clk);
      check_idle("post_song", 0, 3);

      // Stop during the third note
      stop_at = $urandom_range(27, 20);
      pulse_start(0);
      check_rows("pre_stop", 0, 0, stop_at, 1'b0);
      pulse_stop(0);
      check_idle("stopped", 0, 6);
      pulse_start(0);
      check_rows("restart", 0, 0, 12, 1'b0);
      pulse_stop(0);
      check_idle("stopped2", 0, 2);

      // start and stop together while idle
      if0.start = 1'b1;
      if0.stop  = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      if0.stop  = 1'b0;
      check_idle("start_stop_idle", 0, 4);

      // Looping instance wraps to entry 0 in the done cycle
      build_trace(TB_SONG, 1'b1);
      pulse_start(1);
      check_rows("loop", 1, 0, exp_q.size() - 1, 1'b1);
      pulse_stop(1);
      check_idle("loop_stopped", 1, 3);

      // Song whose first entry is the end marker
      pulse_start(2);
      chk("empty_done", obs(2), 19'h40000);
      @(negedge clk);
      check_idle("empty_after", 2, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Note sequencer that drives the piezo tone generator. Steps through a fixed song table, one entry per note, and presents the current note's tone period on `tone_limit` for the tone generator's counter compare. Timing comes from a beat prescaler on the 1 MHz system clock, and a short silent gap separates consecutive notes. It sits directly upstream of the tone stage and runs under control of `start` and `stop` strobes from the panel/control logic.

## Interface
- `BEAT_CYCLES`, default 250000: clocks per beat (0.25 s at 1 MHz). Must be > `GAP_CYCLES`.
- `GAP_CYCLES`, default 20000: silent clocks at the end of every note. Must be ≥ 1.
- `SONG_LEN`, default 16: number of table entries.
- `LOOP`, default 0: 1 = restart from entry 0 after the end instead of stopping.
- `clk` in 1: system clock, 1 MHz.
- `rst` in 1: reset; asynchronous, active-high.
- `start` in 1: one-cycle strobe to begin playback from entry 0.
- `stop` in 1: one-cycle strobe to abort playback.
- `tone_limit` out 12: full tone period in clocks, for the tone generator; 0 = silence.
- `tone_en` out 1: tone generator enable.
- `busy` out 1: high while in PLAY or GAP.
- `done` out 1: one-cycle pulse when the song end is reached.
- `note_idx` out 4: index of the current entry.

## Operation
- Table entry is 6 bits: `{note[3:0], dur[1:0]}`.
- `note` codes:
  - 0 = rest.
  - 1..8 = do, rae, mi, fa, sol, la, ti, high_do, with periods 3830, 3400, 3038, 2864, 2550, 2272, 2028, 1912.
  - 9..15 = rest.
- `dur` codes: 0 = end marker; 1 = 1 beat; 2 = 2 beats; 3 = 4 beats.
- FSM states:
  - IDLE:
    - `start` → PLAY, with `note_idx`=0.
    - If entry 0 has `dur`=0, go straight to end handling: `done` pulses, stay IDLE.
  - PLAY:
    - `tone_limit` = period of the current note; `tone_en` = 1, except for rests, where `tone_limit`=0 and `tone_en`=0.
    - Lasts exactly beats×`BEAT_CYCLES` − `GAP_CYCLES` cycles, then → GAP.
  - GAP:
    - `tone_limit`=0, `tone_en`=0, for exactly `GAP_CYCLES` cycles.
    - Then advance to `note_idx`+1 and → PLAY.
    - End handling: if the next entry has `dur`=0, or `note_idx` = `SONG_LEN`−1, the song has ended:
      - `done` pulses.
      - `LOOP`=0: → IDLE.
      - `LOOP`=1: → PLAY at entry 0.
- `stop` in PLAY or GAP → IDLE next cycle. Outputs are zeroed and `done` does not pulse.
- `stop` has priority over `start` and over end-of-song in the same cycle.
- `start` while `busy` is ignored; there is no restart.
- Note timer width is `$clog2(4*BEAT_CYCLES)`. It counts down from the loaded duration, and a single-cycle load occurs on each state entry.

## Timing
- Reset values: `tone_limit`=0, `tone_en`=0, `busy`=0, `done`=0, `note_idx`=0; state IDLE; timer 0.
- Reset is honoured mid-song; nothing is retained.
- All outputs are registered.
- `start` sampled high at edge k → PLAY outputs valid from edge k+1 (1-cycle latency).
- `done` is high for exactly the one cycle following the last GAP cycle. In that same cycle `busy`=0 (`LOOP`=0), or `busy`=1 with entry 0 playing (`LOOP`=1).
- The note period in PLAY+GAP totals exactly beats×`BEAT_CYCLES`, so there is no drift across notes.
- `stop` sampled at edge k → `tone_en`=0 and `busy`=0 from k+1.

## Structure
- Package `melody_pkg` holds:
  - Note period constants (12-bit) and note codes.
  - Duration codes and the FSM state enum.
  - Default song table: do/1, rae/1, mi/1, fa/1, sol/2, la/1, ti/1, high_do/3, end.
- Sub-module `note_rom`: combinational note code → 12-bit period, returning 0 for rest and reserved codes.
- The song table is a constant array inside `melody_sequencer`.

## Test plan
Benches run with `BEAT_CYCLES`=10 and `GAP_CYCLES`=2.
- Reset mid-PLAY, then release → all outputs 0. Next `start` plays entry 0 (do) with `tone_limit`=3830 one cycle later.
- `start` pulse → do (3830) for 8 cycles, 0 for 2, rae (3400) for 8, 0 for 2. Sol lasts 18 cycles; high_do (dur code 3, 4 beats) lasts 38. `done` pulses once after high_do's gap, then `busy`=0.
- `stop` during the 3rd note (mi, 3038) → next cycle `tone_en`=0, `busy`=0, no `done`. A later `start` begins again at entry 0.
- `start` and `stop` asserted in the same IDLE cycle → remains IDLE. `start` during PLAY → ignored, sequence timing unchanged.
- `LOOP`=1 → after high_do's gap, `done` pulses and `tone_limit`=3830 in the same cycle, with `note_idx`=0.
- Table with entry 0 = end marker → `start` yields a `done` pulse next cycle, `busy` never asserts, `tone_en` stays 0.
